// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams 32-bit big-endian message words out as
// 16-word blocks with the 0x80 marker, zero fill and 64-bit bit-length appended.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [31:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [2:0]  msg_bytes_i,
    output logic        blk_valid_o,
    input  logic        blk_ready_i,
    output logic [31:0] blk_data_o,
    output logic [3:0]  blk_idx_o,
    output logic        blk_end_o,
    output logic        msg_end_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD1,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    state_t           state_q, state_d;
    logic             blk_valid_q;
    logic [31:0]      blk_data_q, word_d;
    logic [3:0]       blk_idx_q;
    logic [3:0]       widx_q;
    logic             blk_end_q;
    logic             msg_end_q, msg_end_d;
    logic             busy_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic [63:0]      len64;
    logic             load;
    logic             slot_free;
    logic [2:0]       nbytes;

    // Keep the n valid leading bytes and place the 0x80 marker right after them.
    function automatic logic [31:0] last_word(input logic [31:0] d, input logic [2:0] n);
        case (n)
            3'd0:    return 32'h8000_0000;
            3'd1:    return {d[31:24], 8'h80, 16'h0000};
            3'd2:    return {d[31:16], 8'h80, 8'h00};
            3'd3:    return {d[31:8], 8'h80};
            default: return d;
        endcase
    endfunction

    // Marker landing at idx 13 leaves exactly the two length slots in this block.
    function automatic state_t after_marker(input logic [3:0] k);
        return (k == 4'd13) ? S_LEN_HI : S_ZERO;
    endfunction

    assign slot_free   = !blk_valid_q || blk_ready_i;
    assign msg_ready_o = !rst_i && (state_q == S_DATA) && slot_free;
    assign nbytes      = (msg_bytes_i > 3'd4) ? 3'd4 : msg_bytes_i;
    assign len64       = 64'(len_q);

    always_comb begin
        load      = 1'b0;
        word_d    = 32'h0000_0000;
        state_d   = state_q;
        len_d     = len_q;
        msg_end_d = 1'b0;
        case (state_q)
            S_DATA: begin
                if (msg_valid_i) begin
                    load = 1'b1;
                    if (!msg_last_i) begin
                        word_d = msg_data_i;
                        len_d  = len_q + LEN_W'(32);
                    end else begin
                        word_d  = last_word(msg_data_i, nbytes);
                        len_d   = len_q + LEN_W'({nbytes, 3'b000});
                        state_d = (nbytes == 3'd4) ? S_PAD1 : after_marker(widx_q);
                    end
                end
            end
            S_PAD1: begin
                load    = 1'b1;
                word_d  = 32'h8000_0000;
                state_d = after_marker(widx_q);
            end
            S_ZERO: begin
                load = 1'b1;
                if (widx_q == 4'd13) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                load    = 1'b1;
                word_d  = len64[63:32];
                state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                load      = 1'b1;
                word_d    = len64[31:0];
                msg_end_d = 1'b1;
                len_d     = '0;
                state_d   = S_DATA;
            end
            default: state_d = S_DATA;
        endcase
    end

    // Single output register stage; everything advances only when a word loads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_DATA;
            blk_valid_q <= 1'b0;
            blk_data_q  <= 32'h0000_0000;
            blk_idx_q   <= 4'd0;
            widx_q      <= 4'd0;
            blk_end_q   <= 1'b0;
            msg_end_q   <= 1'b0;
            busy_q      <= 1'b0;
            len_q       <= '0;
        end else begin
            if (slot_free) blk_valid_q <= load;
            if (slot_free && load) begin
                blk_data_q <= word_d;
                blk_idx_q  <= widx_q;
                blk_end_q  <= (widx_q == 4'd15);
                msg_end_q  <= msg_end_d;
                widx_q     <= widx_q + 4'd1;
                state_q    <= state_d;
                len_q      <= len_d;
                if (msg_end_d) busy_q <= 1'b0;
                else if (state_q == S_DATA) busy_q <= 1'b1;
            end
        end
    end

    assign blk_valid_o = blk_valid_q;
    assign blk_data_o  = blk_data_q;
    assign blk_idx_o   = blk_idx_q;
    assign blk_end_o   = blk_end_q;
    assign msg_end_o   = msg_end_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 core. Accepts an arbitrary-length byte message as a stream of big-endian 32-bit words. Emits it as whole 512-bit blocks of 16 words each, applying FIPS 180-4 padding: a 0x80 marker byte, zero fill, then the 64-bit message bit-length. Output words go straight into the core's text-word write path, and the word index and end flags drive its command sequencing.

Parameters:
LEN_W, 64, width of the internal bit-length counter (legal 32..64). The counter is zero-extended to 64 bits in the length words and wraps modulo 2^LEN_W.

Ports:
clk_i  in  1  global clock, all state on the rising edge
rst_i  in  1  global reset; asynchronous, active-high
msg_valid_i  in  1  input word valid
msg_ready_o  out  1  input word accepted when msg_valid_i && msg_ready_o
msg_data_i  in  32  message word; byte 0 in [31:24]
msg_last_i  in  1  final word of the message
msg_bytes_i  in  3  valid bytes in the final word (0..4, counted from [31:24]); values >4 are treated as 4; ignored unless msg_last_i
blk_valid_o  out  1  output word valid
blk_ready_i  in  1  output word consumed when blk_valid_o && blk_ready_i
blk_data_o  out  32  padded block word
blk_idx_o  out  4  word position in the current block (0..15)
blk_end_o  out  1  this word is idx 15 (block complete)
msg_end_o  out  1  this word is the final length word of the message
busy_o  out  1  a message is in progress

Behaviour:
- Reset (async assert, deassert on clk_i): state=S_DATA, blk_valid_o=0, blk_data_o=0, blk_idx_o=0, blk_end_o=0, msg_end_o=0, busy_o=0, length counter=0, msg_ready_o=0 while rst_i is high.
- Reset mid-message: the partial block and the length are discarded. No output is produced until new input arrives.
- Output is a single register stage. A word may load when !blk_valid_o || blk_ready_i (the "slot free" condition).
- While blk_valid_o=1 and blk_ready_i=0, all blk_* outputs hold stable.
- msg_ready_o = (state==S_DATA) && slot free. Latency from an accepted input word to blk_valid_o is 1 cycle. Full throughput is 1 word/cycle.
- blk_idx_o increments, wrapping 15->0, on each loaded word. blk_end_o = (idx==15).
- busy_o sets on the first accepted input word and clears when the msg_end_o word is loaded.
- States:
  S_DATA: pass accepted words through.
    - Non-last word: output = data; length += 32.
    - Last word with n = 1..3 bytes: output = the n data bytes, then 0x80 in byte n, remaining bytes 0; length += 8n; go to NEXT(idx).
    - Last word with n = 4: output = data; length += 32; go to S_PAD1.
    - Last word with n = 0 (including the empty message): output = 0x80000000, data ignored; go to NEXT(idx).
  S_PAD1: emit 0x80000000; go to NEXT(idx).
  S_ZERO: emit 0x00000000. After emitting at idx 13, go to S_LEN_HI; otherwise stay.
  S_LEN_HI: emit length[63:32] (always at idx 14); go to S_LEN_LO.
  S_LEN_LO: emit length[31:0] at idx 15 with msg_end_o=1. Length counter clears, idx wraps to 0, return to S_DATA.
- NEXT(k), where k is the idx of the marker word: k==13 -> S_LEN_HI; any other k -> S_ZERO.
  - For k = 14 or 15, the zeros run through idx 15, wrap, and continue through idx 0..13 of an extra block.
- Length words are therefore always at idx 14 and 15.
- Input words are never accepted in S_PAD1, S_ZERO, S_LEN_HI or S_LEN_LO.
- A new message may begin the cycle after the S_LEN_LO word loads.
- Length counter arithmetic is unsigned and wraps modulo 2^LEN_W. No error is flagged on overflow.

Test Plan:
- Empty message: one word, last=1, bytes=0.
  -> 16 words: 0x80000000, then 14 x 0x00000000 (idx1..14, with idx14 being length hi=0), then idx15=0x00000000 with msg_end_o=1 and blk_end_o=1.
- "abc": word 0x61626300, last=1, bytes=3.
  -> idx0=0x61626380, idx1..13 zero, idx14=0, idx15=0x00000018; busy_o falls after idx15.
- 13 full words plus a last word of 3 bytes.
  -> marker in idx13, no extra block; idx14=0, idx15=0x000001B8 (440 bits); exactly 16 output words.
- 14 full words, last=1, bytes=4.
  -> idx14=0x80000000 from S_PAD1, zeros to idx15, second block zeros idx0..13, idx15 of block 2 = 0x000001C0; 32 output words total.
- Backpressure: hold blk_ready_i=0 for 3 cycles mid-stream.
  -> blk_data_o and blk_idx_o stay constant, msg_ready_o=0, no word lost or duplicated; the resumed stream matches the unstalled reference.
- Async rst_i pulse between clock edges during S_ZERO of a block.
  -> outputs clear immediately; the following "abc" message produces exactly the single "abc" block above.
